evt_cnt_rd: RTL and testbench

EVT_CNT_RD -- requirements
Module: evt_cnt_rd

---
 rtl/evt_cnt_rd_pkg.sv | 13 +
 rtl/evt_cnt_rd_rd_edge.sv | 31 +++
 rtl/evt_cnt_rd.sv | 104 ++++++++++
 tb/tb_evt_cnt_rd.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/evt_cnt_rd_pkg.sv
// Shared register definitions for the event counter read block:
// FSM state encoding and the default register addresses.
package evt_cnt_rd_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SNAP = 1'b1
    } state_t;

    localparam logic [9:0] DEF_CNT_LO_ADDR = 10'h0;
    localparam logic [9:0] DEF_CNT_HI_ADDR = 10'h1;

endpackage

// File: rtl/evt_cnt_rd_rd_edge.sv
// Read-accept detector: address match gated by the read strobe, reduced to a
// single-cycle pulse on its rising edge so a held strobe accepts only once.
module rd_edge #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] MATCH_ADDR = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_acc
);

    logic hit_p0;
    logic hit_p1;

    assign hit_p0 = i_rd_en && (i_addr == MATCH_ADDR);

    // stage p0 -> p1: remembered strobe, cleared in reset so a strobe held
    // across reset release is accepted on the first cycle out of reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hit_p1 <= 1'b0;
        end else begin
            hit_p1 <= hit_p0;
        end
    end

    assign o_acc = hit_p0 && !hit_p1;

endmodule

// File: rtl/evt_cnt_rd.sv
// 32-bit saturating event counter read through two 16-bit registers:
// a low read snapshots and clears the count, a high read returns the shadow.
module evt_cnt_rd
    import evt_cnt_rd_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 10,
    parameter logic [ADDR_WIDTH-1:0] CNT_LO_ADDR = ADDR_WIDTH'(DEF_CNT_LO_ADDR),
    parameter logic [ADDR_WIDTH-1:0] CNT_HI_ADDR = ADDR_WIDTH'(DEF_CNT_HI_ADDR)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd_en,
    input  logic                  i_event,
    output logic [15:0]           o_rd_data,
    output logic                  o_rd_vld,
    output logic                  o_sat
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_t      state;
    logic [31:0] cnt;
    logic [15:0] shadow_hi;
    logic        acc_lo;
    logic        acc_hi_raw;
    logic        acc_hi;

    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic ev);
        if (ev && (c != CNT_MAX)) begin
            return c + 32'd1;
        end
        return c;
    endfunction

    rd_edge #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MATCH_ADDR (CNT_LO_ADDR)
    ) u_edge_lo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rd_en (i_rd_en),
        .i_addr  (i_addr),
        .o_acc   (acc_lo)
    );

    rd_edge #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MATCH_ADDR (CNT_HI_ADDR)
    ) u_edge_hi (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rd_en (i_rd_en),
        .i_addr  (i_addr),
        .o_acc   (acc_hi_raw)
    );

    // With aliased addresses the low read wins, keeping accepts exclusive
    assign acc_hi = acc_hi_raw && !acc_lo;

    // stage p0 -> p1: counter update, snapshot and registered read response
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shadow_hi <= '0;
            o_rd_data <= '0;
            o_rd_vld  <= 1'b0;
            o_sat     <= 1'b0;
        end else begin
            o_rd_vld <= acc_lo || acc_hi;

            if (acc_lo) begin
                o_rd_data <= cnt[15:0];
                shadow_hi <= cnt[31:16];
                cnt       <= {31'd0, i_event};
                o_sat     <= 1'b0;
            end else begin
                cnt <= sat_inc(cnt, i_event);
                if (i_event && (cnt == CNT_MAX)) begin
                    o_sat <= 1'b1;
                end
                if (acc_hi) begin
                    o_rd_data <= shadow_hi;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (acc_lo) begin
                        state <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    if (acc_hi) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_evt_cnt_rd.sv
// Randomized and directed bench for evt_cnt_rd against a behavioural model.
module tb_evt_cnt_rd;
    import evt_cnt_rd_pkg::*;

    localparam logic [9:0] LO = 10'h0;
    localparam logic [9:0] HI = 10'h1;

    logic        clk;
    logic        rst_n;
    logic [9:0]  addr;
    logic        rd_en;
    logic        ev;
    logic [15:0] rd_data;
    logic        rd_vld;
    logic        sat;

    int n_chk;
    int n_err;
    int vld_seen;

    // Reference model state
    logic [31:0] m_cnt;
    logic [15:0] m_shadow;
    logic [15:0] m_data;
    logic        m_vld;
    logic        m_sat;
    logic        m_snap;
    logic        m_prev_lo;
    logic        m_prev_hi;

    evt_cnt_rd dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_addr    (addr),
        .i_rd_en   (rd_en),
        .i_event   (ev),
        .o_rd_data (rd_data),
        .o_rd_vld  (rd_vld),
        .o_sat     (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs from a negedge, advance the model, check #1 after the edge
    task automatic step(input logic rn, input logic e, input logic rd, input logic [9:0] a);
        logic lo_hit, hi_hit, a_lo, a_hi;
        rst_n = rn;
        ev    = e;
        rd_en = rd;
        addr  = a;
        @(posedge clk);
        if (!rn) begin
            m_cnt = '0; m_shadow = '0; m_data = '0; m_vld = 1'b0;
            m_sat = 1'b0; m_snap = 1'b0; m_prev_lo = 1'b0; m_prev_hi = 1'b0;
        end else begin
            lo_hit = rd && (a == LO);
            hi_hit = rd && (a == HI);
            a_lo = lo_hit && !m_prev_lo;
            a_hi = hi_hit && !m_prev_hi && !a_lo;
            m_prev_lo = lo_hit;
            m_prev_hi = hi_hit;
            m_vld = a_lo || a_hi;
            if (a_lo) begin
                m_data   = m_cnt[15:0];
                m_shadow = m_cnt[31:16];
                m_cnt    = e ? 32'd1 : 32'd0;
                m_sat    = 1'b0;
                m_snap   = 1'b1;
            end else begin
                if (e) begin
                    if (m_cnt == 32'hFFFF_FFFF) m_sat = 1'b1;
                    else m_cnt = m_cnt + 32'd1;
                end
                if (a_hi) begin
                    m_data = m_shadow;
                    m_snap = 1'b0;
                end
            end
        end
        #1;
        check("rd_vld", 32'(rd_vld), 32'(m_vld));
        check("rd_data", 32'(rd_data), 32'(m_data));
        check("sat", 32'(sat), 32'(m_sat));
        if (rd_vld) vld_seen++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 10'h3);
    endtask

    task automatic events(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 10'h3);
    endtask

    initial begin
        n_chk = 0; n_err = 0; vld_seen = 0;
        rst_n = 1'b0; ev = 1'b0; rd_en = 1'b0; addr = '0;
        m_cnt = '0; m_shadow = '0; m_data = '0; m_vld = 1'b0;
        m_sat = 1'b0; m_snap = 1'b0; m_prev_lo = 1'b0; m_prev_hi = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b1, 1'b1, LO);
        step(1'b0, 1'b0, 1'b0, LO);
        check("rst_cnt", dut.cnt, 32'h0);
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        check("rst_vld", 32'(rd_vld), 32'h0);
        check("rst_data", 32'(rd_data), 32'h0);

        // Five events, low then high read
        events(5);
        step(1'b1, 1'b0, 1'b1, LO);
        check("e5_lo_vld", 32'(rd_vld), 32'h1);
        check("e5_lo_data", 32'(rd_data), 32'h0005);
        check("e5_state", 32'(dut.state), 32'(ST_SNAP));
        step(1'b1, 1'b0, 1'b0, LO);
        check("e5_vld_drop", 32'(rd_vld), 32'h0);
        check("e5_data_hold", 32'(rd_data), 32'h0005);
        step(1'b1, 1'b0, 1'b1, HI);
        check("e5_hi_data", 32'(rd_data), 32'h0000);
        check("e5_cnt", dut.cnt, 32'h0);
        idle(1);

        // 70000 events spanning the half boundary
        events(70000);
        step(1'b1, 1'b0, 1'b1, LO);
        check("big_lo", 32'(rd_data), 32'h1170);
        idle(1);
        step(1'b1, 1'b0, 1'b1, HI);
        check("big_hi", 32'(rd_data), 32'h0001);
        idle(1);
        check("big_state", 32'(dut.state), 32'(ST_IDLE));

        // Held strobe yields one accept
        events(3);
        vld_seen = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, LO);
        check("hold_pulses", 32'(vld_seen), 32'd1);
        check("hold_data", 32'(rd_data), 32'h0003);
        check("hold_cnt", dut.cnt, 32'h0);
        idle(1);

        // Address switch while strobe held is a fresh accept
        events(2);
        step(1'b1, 1'b0, 1'b1, LO);
        step(1'b1, 1'b0, 1'b1, HI);
        check("switch_vld", 32'(rd_vld), 32'h1);
        check("switch_data", 32'(rd_data), 32'h0000);
        idle(1);

        // Same-cycle event with low accept belongs to the new period
        events(9);
        step(1'b1, 1'b1, 1'b1, LO);
        check("same_lo", 32'(rd_data), 32'h0009);
        idle(1);
        step(1'b1, 1'b0, 1'b1, LO);
        check("same_next", 32'(rd_data), 32'h0001);
        idle(1);

        // Saturation
        force dut.cnt = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        step(1'b1, 1'b0, 1'b0, 10'h3);
        release dut.cnt;
        events(3);
        check("sat_cnt", dut.cnt, 32'hFFFF_FFFF);
        check("sat_flag", 32'(sat), 32'h1);
        step(1'b1, 1'b0, 1'b1, LO);
        check("sat_lo", 32'(rd_data), 32'hFFFF);
        check("sat_clr", 32'(sat), 32'h0);
        idle(1);

        // Reset discards a pending snapshot
        events(4);
        step(1'b1, 1'b0, 1'b1, LO);
        step(1'b0, 1'b0, 1'b0, LO);
        step(1'b1, 1'b0, 1'b1, HI);
        check("rst_hi_vld", 32'(rd_vld), 32'h1);
        check("rst_hi_data", 32'(rd_data), 32'h0000);
        idle(1);

        // Strobe held across reset release accepts on the first cycle out
        events(6);
        step(1'b0, 1'b0, 1'b1, LO);
        step(1'b1, 1'b0, 1'b1, LO);
        check("rel_vld", 32'(rd_vld), 32'h1);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] a;
            case ($urandom_range(0, 3))
                0: a = LO;
                1: a = HI;
                2: a = 10'h2;
                default: a = 10'h3FF;
            endcase
            step(($urandom_range(0, 199) != 0), 1'($urandom), ($urandom_range(0, 2) == 0), a);
            check("rnd_cnt", dut.cnt, m_cnt);
            check("rnd_state", 32'(dut.state), m_snap ? 32'(ST_SNAP) : 32'(ST_IDLE));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
